// File: rtl/rr_packet_mux_arbiter_pkg.sv
// Shared types for the round-robin packet mux arbiter.
package rr_arb_pkg;
    typedef enum logic {IDLE, BUSY} arb_state_t;
    localparam int N_REQ = 4;
    typedef logic [1:0] req_idx_t;
endpackage

// File: rtl/rr_packet_mux_arbiter_if.sv
// Requester-side and downstream handshake bundle; master = arbiter, slave = environment.
interface rr_arb_if #(parameter int WIDTH = 4);
    import rr_arb_pkg::*;
    logic [N_REQ-1:0] in_vld;
    logic [N_REQ-1:0] in_last;
    logic [WIDTH-1:0] in_data [0:N_REQ-1];
    logic [N_REQ-1:0] in_rdy;
    logic             out_vld;
    logic             out_last;
    logic [WIDTH-1:0] out_data;
    logic             out_rdy;

    modport master (input in_vld, in_last, in_data, out_rdy,
                    output in_rdy, out_vld, out_last, out_data);
    modport slave  (output in_vld, in_last, in_data, out_rdy,
                    input in_rdy, out_vld, out_last, out_data);
endinterface

// File: rtl/rr_packet_mux_arbiter_pick.sv
// Rotating-priority encoder: first set request scanning ptr, ptr+1, ... mod 4.
// Purely combinational.
module rr_pick_4
    import rr_arb_pkg::*;
(
    input  logic [N_REQ-1:0] req_i,
    input  req_idx_t         ptr_i,
    output logic             any_o,
    output req_idx_t         idx_o
);
    req_idx_t cand;

    assign any_o = |req_i;

    // Scan from farthest to nearest so the nearest set request wins last.
    always_comb begin
        idx_o = '0;
        cand  = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            cand = ptr_i + req_idx_t'(k);
            if (req_i[cand]) idx_o = cand;
        end
    end
endmodule

// File: rtl/rr_packet_mux_arbiter.sv
// Round-robin 4:1 packet mux; grant held from first beat through 'last' or MAX_BEATS.
// Zero-latency combinational data path while granted; one idle cycle between packets.
module rr_packet_mux_arbiter
    import rr_arb_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter int MAX_BEATS = 16
) (
    input  logic      clk_i,
    input  logic      rst_i,
    rr_arb_if.master  bus,
    output req_idx_t  sel_o,
    output logic      busy_o,
    output logic      timeout_o
);
    localparam int CW = (MAX_BEATS > 2) ? $clog2(MAX_BEATS) : 1;

    arb_state_t    state_q, state_d;
    req_idx_t      sel_q, sel_d;
    req_idx_t      ptr_q, ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          timeout_q, timeout_d;

    logic          pick_any;
    req_idx_t      pick_idx;
    logic          xfer;
    logic [WIDTH-1:0] mux_dat;

    rr_pick_4 u_pick (
        .req_i (bus.in_vld),
        .ptr_i (ptr_q),
        .any_o (pick_any),
        .idx_o (pick_idx)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            sel_q     <= '0;
            ptr_q     <= '0;
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            sel_q     <= sel_d;
            ptr_q     <= ptr_d;
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign mux_dat      = bus.in_data[sel_q];
    assign bus.out_data = mux_dat;

    always_comb begin
        state_d      = state_q;
        sel_d        = sel_q;
        ptr_d        = ptr_q;
        cnt_d        = cnt_q;
        timeout_d    = 1'b0;
        bus.out_vld  = 1'b0;
        bus.out_last = 1'b0;
        bus.in_rdy   = '0;
        xfer         = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (pick_any) begin
                    sel_d   = pick_idx;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                bus.out_vld       = bus.in_vld[sel_q];
                bus.out_last      = bus.in_last[sel_q];
                bus.in_rdy[sel_q] = bus.out_rdy;
                xfer              = bus.out_vld && bus.out_rdy;
                if (xfer) begin
                    cnt_d = cnt_q + 1'b1;
                    // Either a real 'last' or the beat cap ends the grant.
                    if (bus.out_last || cnt_q == CW'(MAX_BEATS - 1)) begin
                        state_d   = IDLE;
                        ptr_d     = sel_q + 2'd1;
                        cnt_d     = '0;
                        timeout_d = !bus.out_last;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign sel_o     = sel_q;
    assign busy_o    = (state_q == BUSY);
    assign timeout_o = timeout_q;
endmodule
